// File: rtl/spi_ram_cmd_ctrl.sv
// Command sequencer between the SPI slave receive path and a single-port synchronous RAM.
// Build option: define ADDR_AUTOINC_EN to post-increment the address registers on accepted WRITE/READ.
module spi_ram_cmd_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              err
);

  localparam int TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

`ifdef ADDR_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_SET_WADDR = 2'b00,
    CMD_WRITE     = 2'b01,
    CMD_SET_RADDR = 2'b10,
    CMD_READ      = 2'b11
  } cmd_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_vld_q;
  logic              rd_vld_q;
  logic [TMR_W-1:0]  timer_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              err_q;

  cmd_t              cmd;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  assign cmd     = cmd_t'(rx_data[9:8]);
  assign pl_addr = rx_data[ADDR_W-1:0];
  assign pl_data = rx_data[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_vld_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      timer_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (ss_n) begin
        // Frame ended: abort silently, forget both addresses, keep RAM bus values.
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        wr_vld_q  <= 1'b0;
        rd_vld_q  <= 1'b0;
        wr_addr_q <= '0;
        rd_addr_q <= '0;
        timer_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rx_valid) begin
              unique case (cmd)
                CMD_SET_WADDR: begin
                  wr_addr_q <= pl_addr;
                  wr_vld_q  <= 1'b1;
                end
                CMD_WRITE: begin
                  if (wr_vld_q) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= wr_addr_q;
                    mem_wdata_q <= pl_data;
                    wr_addr_q   <= wr_addr_q + ADDR_STEP;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                CMD_SET_RADDR: begin
                  rd_addr_q <= pl_addr;
                  rd_vld_q  <= 1'b1;
                end
                CMD_READ: begin
                  if (rd_vld_q) begin
                    mem_re_q   <= 1'b1;
                    mem_addr_q <= rd_addr_q;
                    rd_addr_q  <= rd_addr_q + ADDR_STEP;
                    timer_q    <= '0;
                    state_q    <= RD_WAIT;
                    busy_q     <= 1'b1;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                default: err_q <= 1'b1;
              endcase
            end
          end
          RD_WAIT: begin
            timer_q <= timer_q + 1'b1;
            if (rx_valid) begin
              err_q <= 1'b1;
            end
            // Data arriving on the last timer cycle still wins over the timeout.
            if (mem_rvalid) begin
              tx_data_q  <= 8'(mem_rdata);
              tx_valid_q <= 1'b1;
              state_q    <= RESP;
            end else if (timer_q == TMR_LAST) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          RESP: begin
            if (rx_valid) begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_ram_cmd_ctrl.sv
// Scoreboard bench for spi_ram_cmd_ctrl: driver pushes expected strobes (kind, cycle, addr, data),
// monitor pops them as the DUT raises err / mem_we / mem_re / tx_valid. Honours ADDR_AUTOINC_EN.
module tb_spi_ram_cmd_ctrl;

  localparam int RD_TO = 15;
  localparam int K_ERR = 0;
  localparam int K_WE  = 1;
  localparam int K_RE  = 2;
  localparam int K_TX  = 3;
  localparam int M_PLAIN = 0;
  localparam int M_EXTRA = 1;
  localparam int M_SS    = 2;
  localparam int M_RST   = 3;
`ifdef ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       mem_rvalid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       err;

  spi_ram_cmd_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_TIMEOUT(RD_TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss_n       (ss_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];

  // Environment RAM (responder) and the reference model's view of memory.
  logic [7:0] ram   [256];
  logic [7:0] mem_m [256];
  int         rd_lat = 0;
  int         pend_cnt = 0;
  logic [7:0] pend_addr = 8'h00;

  // Reference model state.
  logic [7:0] wr_addr_m, rd_addr_m, last_addr_m, last_wdata_m;
  bit         wr_vld_m, rd_vld_m;

  function automatic string kname(input int k);
    case (k)
      K_ERR:   return "err";
      K_WE:    return "mem_we";
      K_RE:    return "mem_re";
      default: return "tx_valid";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input int k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: cyc=%0d a=%h d=%h, nothing expected", kname(k), cyc, a, d);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc ||
        (k == K_WE && (e.a !== a || e.d !== d)) ||
        (k == K_RE && e.a !== a) || (k == K_TX && e.d !== d)) begin
      bad++;
      $display("FAIL event: got %s cyc=%0d a=%h d=%h, want %s cyc=%0d a=%h d=%h",
               kname(k), cyc, a, d, kname(e.kind), e.cyc, e.a, e.d);
    end else begin
      $display("ok %s cyc=%0d a=%h d=%h", kname(k), cyc, a, d);
    end
  endtask

  // Monitor: fixed order so same-cycle strobes match the push order.
  initial begin
    forever begin
      @(negedge clk);
      if (err      === 1'b1) mon_ev(K_ERR, 8'h00, 8'h00);
      if (mem_we   === 1'b1) mon_ev(K_WE, mem_addr, mem_wdata);
      if (mem_re   === 1'b1) mon_ev(K_RE, mem_addr, 8'h00);
      if (tx_valid === 1'b1) mon_ev(K_TX, 8'h00, tx_data);
    end
  end

  // RAM responder: returns ram[addr] rd_lat cycles after mem_re (rd_lat=0: never answers).
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = ram[pend_addr];
        end
      end
      if (mem_re === 1'b1 && rd_lat > 0) begin
        pend_addr = mem_addr;
        pend_cnt  = rd_lat;
      end
    end
  end

  task automatic model_clear();
    wr_vld_m = 1'b0; rd_vld_m = 1'b0;
    wr_addr_m = 8'h00; rd_addr_m = 8'h00;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("addr_hold", mem_addr, last_addr_m);
    chk("wdata_hold", mem_wdata, last_wdata_m);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got none, want %0d more starting %s at cyc %0d",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic t_setw(input logic [7:0] a);
    rx_data = {2'b00, a}; rx_valid = 1'b1;
    wr_addr_m = a; wr_vld_m = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    settle();
  endtask

  task automatic t_setr(input logic [7:0] a);
    rx_data = {2'b10, a}; rx_valid = 1'b1;
    rd_addr_m = a; rd_vld_m = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    settle();
  endtask

  task automatic t_write(input logic [7:0] d);
    int t;
    t = cyc;
    rx_data = {2'b01, d}; rx_valid = 1'b1;
    if (wr_vld_m) begin
      push(K_WE, t + 1, wr_addr_m, d);
      mem_m[wr_addr_m] = d;
      last_addr_m = wr_addr_m;
      last_wdata_m = d;
      if (AUTOINC) wr_addr_m = wr_addr_m + 8'd1;
    end else begin
      push(K_ERR, t + 1, 8'h00, 8'h00);
    end
    @(negedge clk); rx_valid = 1'b0;
    settle();
  endtask

  // READ with optional disturbance j cycles into RD_WAIT: extra rx word, ss_n pulse or reset.
  task automatic t_read(input int lat, input int mode, input int j);
    int t;
    bit hit;
    bit data_ok;
    logic [7:0] ed;
    rd_lat = lat;
    data_ok = (lat >= 1 && lat <= RD_TO - 1);
    t = cyc;
    rx_data = {2'b11, 8'($urandom)}; rx_valid = 1'b1;
    hit = rd_vld_m;
    if (!hit) begin
      push(K_ERR, t + 1, 8'h00, 8'h00);
    end else begin
      push(K_RE, t + 1, rd_addr_m, 8'h00);
      ed = mem_m[rd_addr_m];
      last_addr_m = rd_addr_m;
      if (AUTOINC) rd_addr_m = rd_addr_m + 8'd1;
      if (mode == M_EXTRA) push(K_ERR, t + 2 + j, 8'h00, 8'h00);
      if (mode == M_PLAIN || mode == M_EXTRA) begin
        if (data_ok) push(K_TX, t + 2 + lat, 8'h00, ed);
        else         push(K_ERR, t + 1 + RD_TO, 8'h00, 8'h00);
      end
    end
    @(negedge clk); rx_valid = 1'b0;
    if (hit) begin
      chk("busy_rd", busy, 1);
      repeat (j) @(negedge clk);
      case (mode)
        M_EXTRA: begin
          rx_data = 10'($urandom); rx_valid = 1'b1;
          @(negedge clk); rx_valid = 1'b0;
        end
        M_SS: begin
          ss_n = 1'b1;
          @(negedge clk); ss_n = 1'b0;
          model_clear();
        end
        M_RST: begin
          rst = 1'b1;
          repeat (2) @(negedge clk);
          rst = 1'b0;
          model_clear();
          last_addr_m = 8'h00; last_wdata_m = 8'h00;
        end
        default: ;
      endcase
    end
    settle();
  endtask

  task automatic t_ss(input bit with_rx);
    ss_n = 1'b1;
    if (with_rx) begin
      rx_data = 10'($urandom); rx_valid = 1'b1;
    end
    @(negedge clk);
    ss_n = 1'b0; rx_valid = 1'b0;
    model_clear();
    settle();
  endtask

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(240, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1; ss_n = 1'b0; rx_valid = 1'b0; rx_data = 10'h000;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00; mem_m[i] = 8'h00;
    end
    model_clear();
    last_addr_m = 8'h00; last_wdata_m = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    t_write(8'h55);
    t_setw(8'h12);
    t_write(8'hAB);
    t_setr(8'h12);
    t_read(2, M_PLAIN, 0);
    t_setr(8'h12);
    t_read(0, M_EXTRA, 5);
    t_setw(8'h20);
    t_ss(1'b0);
    t_write(8'h33);
    t_setr(8'h12);
    t_read(5, M_SS, 2);
    t_setr(8'h12);
    t_read(14, M_PLAIN, 0);
    t_read(15, M_PLAIN, 0);
    t_setr(8'h12);
    t_read(14, M_EXTRA, 14);
    t_setw(8'hFF);
    t_write(8'h01);
    t_write(8'h02);
    t_write(8'h03);
    t_ss(1'b1);
    t_write(8'h44);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int k;
      int lat;
      int mode;
      int lim;
      int j;
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    t_setw(rnd_addr());
        2, 3, 4: t_write(8'($urandom));
        5:       t_setr(rnd_addr());
        6, 7, 8: begin
          lat  = $urandom_range(0, 16);
          mode = $urandom_range(0, 3);
          lim  = (lat >= 1 && lat <= RD_TO - 1) ? lat : RD_TO;
          if (mode == M_EXTRA) j = (lim == RD_TO) ? $urandom_range(0, RD_TO - 2) : $urandom_range(0, lat);
          else                 j = $urandom_range(0, lim - 1);
          t_read(lat, mode, j);
        end
        default: t_ss(1'($urandom_range(0, 1)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
